instruction_fetch_unit: RTL and testbench

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

---
 rtl/instruction_fetch_unit.sv | 109 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: single-outstanding fetch FSM
// with branch redirect, response discard and decode handshake.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [6:0]  opcode,
  output logic        misalign_err
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD
  } state_t;

  state_t      state;
  state_t      state_n;
  logic [31:0] pc;
  logic [31:0] pc_n;
  logic        discard;
  logic        discard_n;
  logic        capture;

  assign imem_req    = (state == REQ);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign opcode      = instr_valid ? instr[6:0] : 7'b0000000;

  // Next-state, next-pc and discard-flag logic
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    discard_n = discard;
    capture   = 1'b0;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        if (branch_taken) begin
          // a grant in the redirect cycle still yields a response
          discard_n = imem_gnt;
          state_n   = imem_gnt ? WAIT : REQ;
        end else if (imem_gnt) begin
          state_n = WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          discard_n = 1'b0;
          if (discard || branch_taken) begin
            state_n = REQ;
          end else begin
            capture = 1'b1;
            state_n = HOLD;
          end
        end else if (branch_taken) begin
          discard_n = 1'b1;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          state_n = REQ;
        end else if (instr_ready) begin
          state_n = REQ;
          pc_n    = pc + 32'd4;
        end
      end
      default: state_n = IDLE;
    endcase
    if (branch_taken) begin
      pc_n = {branch_target[31:2], 2'b00};
    end
  end

  // State, pc, held instruction and error pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      pc           <= RESET_PC;
      discard      <= 1'b0;
      instr        <= 32'h0;
      instr_pc     <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_n;
      pc           <= pc_n;
      discard      <= discard_n;
      misalign_err <= branch_taken && (branch_target[1:0] != 2'b00);
      if (capture) begin
        instr    <= imem_rdata;
        instr_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed table-driven bench for instruction_fetch_unit.
// Each row: inputs for one cycle and expected outputs seen in it.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [6:0]  opcode;
  logic        misalign_err;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr(instr),
    .instr_pc(instr_pc),
    .opcode(opcode),
    .misalign_err(misalign_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        gnt;
    logic        rv;
    logic [31:0] rdata;
    logic        br;
    logic [31:0] bt;
    logic        rdy;
    logic [105:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(
    input logic rs, input logic g, input logic rv,
    input logic [31:0] rd, input logic b, input logic [31:0] t,
    input logic rdy, input logic req, input logic [31:0] addr,
    input logic val, input logic [31:0] ins, input logic [31:0] ipc,
    input logic [6:0] op, input logic mis);
    vec_t v;
    v.rst = rs; v.gnt = g; v.rv = rv; v.rdata = rd;
    v.br = b; v.bt = t; v.rdy = rdy;
    v.exp = {req, addr, val, ins, ipc, op, mis};
    tbl.push_back(v);
  endfunction

  function automatic logic [105:0] got();
    return {imem_req, imem_addr, instr_valid, instr,
            instr_pc, opcode, misalign_err};
  endfunction

  task automatic check(input string name, input logic [105:0] a,
                       input logic [105:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", name, a, e);
    end
  endtask

  localparam logic [31:0] I1 = 32'h0040_0093;
  localparam logic [31:0] I2 = 32'h00A0_0513;
  localparam logic [31:0] FC = 32'hFFFF_FFFC;

  initial begin
    // rst gnt rv rdata br bt rdy | req addr val instr ipc op mis
    add(1,0,0,0,0,0,0,          0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,0,          0,0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,          1,0,0,0,0,0,0);
    add(0,0,1,32'h33,0,0,0,     0,0,0,0,0,0,0);
    add(0,0,0,0,0,0,1,          0,0,1,32'h33,0,7'h33,0);
    add(0,0,0,0,0,0,0,          1,4,0,32'h33,0,0,0);
    add(0,0,0,0,0,0,0,          1,4,0,32'h33,0,0,0);
    add(0,1,0,0,0,0,0,          1,4,0,32'h33,0,0,0);
    add(0,0,0,0,0,0,0,          0,4,0,32'h33,0,0,0);
    add(0,0,1,I1,0,0,0,         0,4,0,32'h33,0,0,0);
    for (int i = 0; i < 5; i++)
      add(0,0,0,0,0,0,0,        0,4,1,I1,4,7'h13,0);
    add(0,0,0,0,0,0,1,          0,4,1,I1,4,7'h13,0);
    add(0,1,0,0,0,0,0,          1,8,0,I1,4,0,0);
    add(0,0,0,0,1,32'h100,0,    0,8,0,I1,4,0,0);
    add(0,0,0,0,0,0,0,          0,32'h100,0,I1,4,0,0);
    add(0,0,1,32'hDEADBEEF,0,0,0, 0,32'h100,0,I1,4,0,0);
    add(0,0,0,0,0,0,0,          1,32'h100,0,I1,4,0,0);
    add(0,0,0,0,1,32'h102,0,    1,32'h100,0,I1,4,0,0);
    add(0,0,0,0,0,0,0,          1,32'h100,0,I1,4,0,1);
    add(0,0,0,0,1,FC,0,         1,32'h100,0,I1,4,0,0);
    add(0,1,0,0,0,0,0,          1,FC,0,I1,4,0,0);
    add(0,0,1,32'h6F,0,0,0,     0,FC,0,I1,4,0,0);
    add(0,0,0,0,0,0,1,          0,FC,1,32'h6F,FC,7'h6F,0);
    add(0,1,0,0,1,32'h200,0,    1,0,0,32'h6F,FC,0,0);
    add(0,0,1,32'h13,0,0,0,     0,32'h200,0,32'h6F,FC,0,0);
    add(0,1,0,0,0,0,0,          1,32'h200,0,32'h6F,FC,0,0);
    add(0,0,1,32'h37,0,0,0,     0,32'h200,0,32'h6F,FC,0,0);
    add(0,0,0,0,1,32'h300,1,    0,32'h200,1,32'h37,32'h200,7'h37,0);
    add(0,1,0,0,0,0,0,          1,32'h300,0,32'h37,32'h200,0,0);
    add(0,0,1,32'h33,1,32'h400,0, 0,32'h300,0,32'h37,32'h200,0,0);
    add(0,1,0,0,0,0,0,          1,32'h400,0,32'h37,32'h200,0,0);
    add(1,0,0,0,0,0,0,          0,32'h400,0,32'h37,32'h200,0,0);
    add(0,0,1,32'hBAD,0,0,0,    0,0,0,0,0,0,0);
    add(0,0,1,32'hBAD,0,0,0,    1,0,0,0,0,0,0);
    add(0,1,0,0,0,0,0,          1,0,0,0,0,0,0);
    add(0,0,1,I2,0,0,0,         0,0,0,0,0,0,0);
    add(0,0,1,32'hFFFF,0,0,0,   0,0,1,I2,0,7'h13,0);
    add(0,0,0,0,1,32'h40,0,     0,0,1,I2,0,7'h13,0);
    add(0,0,0,0,0,0,0,          1,32'h40,0,I2,0,0,0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst           = tbl[i].rst;
      imem_gnt      = tbl[i].gnt;
      imem_rvalid   = tbl[i].rv;
      imem_rdata    = tbl[i].rdata;
      branch_taken  = tbl[i].br;
      branch_target = tbl[i].bt;
      instr_ready   = tbl[i].rdy;
      #1;
      check($sformatf("row%0d", i), got(), tbl[i].exp);
    end

    // grant, then rvalid three cycles later: valid one cycle after it
    @(negedge clk);
    imem_gnt = 1'b1;
    #1;
    check("lat_req", {imem_req, imem_addr}, {1'b1, 32'h40});
    @(negedge clk);
    imem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check($sformatf("lat_wait%0d", k), {imem_req, instr_valid}, 2'b00);
      @(negedge clk);
    end
    imem_rvalid = 1'b1;
    imem_rdata  = 32'h0000_0013;
    #1;
    check("lat_rv", {31'h0, instr_valid}, 32'h0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    #1;
    check("lat_hold", {instr_valid, instr, instr_pc, opcode},
          {1'b1, 32'h13, 32'h40, 7'h13});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
